// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: definitions shared by the ALU execution unit and its
// combinational datapath.
//   ALU_WIDTH   - default datapath width
//   alu_op_e    - operation select encodings
//   alu_state_e - controller state encodings
//   rot_amount  - rotate distance from the low operand bits
package alu_exec_pkg;

  localparam int unsigned ALU_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_XAO = 2'b00,
    OP_ROR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXEC   = 2'b01,
    ROTATE = 2'b10,
    DONE   = 2'b11
  } alu_state_e;

  // Rotate distance is b[2:0] reduced modulo the datapath width, so a
  // distance equal to the width collapses to zero and skips rotation.
  function automatic logic [2:0] rot_amount(input logic [2:0] b_lo,
                                            input int unsigned width);
    return 3'(int'(b_lo) % width);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational result and flag generation.
// Ports:
//   i_a, i_b   - latched operands
//   i_op       - latched operation
//   i_rot_val  - finished rotate value, passed through when i_op is OP_ROR
//   o_result   - operation result
//   o_cf       - carry (ADD) / borrow (SUB), 0 otherwise
//   o_sf, o_zf, o_gt - sign, zero and non-zero flags of o_result
module alu_comb
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_rot_val,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cf,
  output logic             o_sf,
  output logic             o_zf,
  output logic             o_gt
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // With a zero-extended subtraction the extra MSB is set exactly when a < b.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_cf     = 1'b0;
    case (i_op)
      OP_XAO:  o_result = (~(i_a ^ i_b)) | (i_a & i_b);
      OP_ROR:  o_result = i_rot_val;
      OP_ADD:  {o_cf, o_result} = w_sum;
      OP_SUB:  {o_cf, o_result} = w_diff;
      default: ;
    endcase
  end

  assign o_zf = (o_result == '0);
  assign o_sf = o_result[WIDTH-1];
  assign o_gt = (o_result != '0);

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU with a start/busy/valid handshake.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - execute request, sampled only while idle
//   a, b   - operands, op - operation select
//   result - registered result, held until the next completion
//   gt_zero_flag, SF, CF, ZF - registered flags of result
//   busy   - high whenever not idle
//   valid  - one-cycle pulse when result/flags are updated
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             gt_zero_flag,
  output logic             SF,
  output logic             CF,
  output logic             ZF,
  output logic             busy,
  output logic             valid
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_op_e          r_op;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_result;
  logic             r_cf;
  logic             r_sf;
  logic             r_zf;
  logic             r_gt;

  logic [2:0]       w_rot_n;
  logic [WIDTH-1:0] w_rot_step;
  logic [WIDTH-1:0] w_rot_val;
  logic             w_load_result;
  logic [WIDTH-1:0] w_res;
  logic             w_cf;
  logic             w_sf;
  logic             w_zf;
  logic             w_gt;

  assign w_rot_n    = rot_amount(r_b[2:0], WIDTH);
  assign w_rot_step = {r_work[0], r_work[WIDTH-1:1]};
  // A zero-distance rotate finishes in EXEC with the unrotated operand;
  // otherwise the value is captured on the last ROTATE step.
  assign w_rot_val  = (r_state == ROTATE) ? w_rot_step : r_a;
  // DONE is only ever entered from EXEC or ROTATE, and that is the one edge
  // where the visible result changes.
  assign w_load_result = (w_state_next == DONE);

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_op      (r_op),
    .i_rot_val (w_rot_val),
    .o_result  (w_res),
    .o_cf      (w_cf),
    .o_sf      (w_sf),
    .o_zf      (w_zf),
    .o_gt      (w_gt)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        if ((r_op == OP_ROR) && (w_rot_n != 3'd0)) begin
          w_state_next = ROTATE;
        end else begin
          w_state_next = DONE;
        end
      end
      ROTATE: begin
        // The counter reaches zero with this step.
        if (r_cnt <= 3'd1) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch and rotate working register / counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_XAO;
      r_cnt  <= '0;
      r_work <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= alu_op_e'(op);
          end
        end
        EXEC: begin
          r_work <= r_a;
          r_cnt  <= (r_op == OP_ROR) ? w_rot_n : 3'd0;
        end
        ROTATE: begin
          r_work <= w_rot_step;
          r_cnt  <= r_cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Visible result and flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result <= '0;
      r_cf     <= 1'b0;
      r_sf     <= 1'b0;
      r_zf     <= 1'b1;
      r_gt     <= 1'b0;
    end else if (w_load_result) begin
      r_result <= w_res;
      r_cf     <= w_cf;
      r_sf     <= w_sf;
      r_zf     <= w_zf;
      r_gt     <= w_gt;
    end
  end

  assign result       = r_result;
  assign CF           = r_cf;
  assign SF           = r_sf;
  assign ZF           = r_zf;
  assign gt_zero_flag = r_gt;
  assign busy         = (r_state != IDLE);
  assign valid        = (r_state == DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized and directed self-checking bench for
// alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W    = 6;
  localparam int MOD  = 64;
  localparam int MASK = 63;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic [W-1:0] result;
  logic         gt_zero_flag;
  logic         SF;
  logic         CF;
  logic         ZF;
  logic         busy;
  logic         valid;

  int n_tests = 0;
  int n_fail  = 0;
  int prev_result = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .op           (op),
    .result       (result),
    .gt_zero_flag (gt_zero_flag),
    .SF           (SF),
    .CF           (CF),
    .ZF           (ZF),
    .busy         (busy),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: result, carry/borrow and edges from start sample to valid.
  function automatic void ref_model(input int ia, input int ib, input int iop,
                                    output int r, output int cf, output int lat);
    int n;
    int s;
    lat = 2;
    cf  = 0;
    case (iop)
      0: r = (~(ia ^ ib)) & MASK;      // XNOR-or-AND reduces to XNOR
      1: begin
        n   = (ib % 8) % W;
        r   = ((ia >> n) | (ia << (W - n))) & MASK;
        lat = 2 + n;
      end
      2: begin
        s  = ia + ib;
        r  = s % MOD;
        cf = (s >= MOD) ? 1 : 0;
      end
      default: begin
        r  = (ia - ib + MOD) % MOD;
        cf = (ia < ib) ? 1 : 0;
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_op(input int ia, input int ib, input int iop,
                        input bit repulse, input string name);
    int er, ecf, elat, edges;
    ref_model(ia, ib, iop, er, ecf, elat);
    a = W'(ia);
    b = W'(ib);
    op = 2'(iop);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    edges = 1;
    if (!repulse) start = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 2'($urandom);
    while (valid !== 1'b1 && edges < 16) begin
      check_val({name, ":busy"}, 32'(busy), 1);
      check_val({name, ":hold"}, 32'(result), prev_result);
      if (repulse) start = ~start;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check_val({name, ":latency"}, edges, elat);
    check_val({name, ":result"}, 32'(result), er);
    check_val({name, ":CF"}, 32'(CF), ecf);
    check_val({name, ":ZF"}, 32'(ZF), (er == 0) ? 1 : 0);
    check_val({name, ":SF"}, 32'(SF), (er >= MOD / 2) ? 1 : 0);
    check_val({name, ":GT"}, 32'(gt_zero_flag), (er != 0) ? 1 : 0);
    check_val({name, ":busy_done"}, 32'(busy), 1);
    $display("[TB] %s op=%0d a=%0d b=%0d -> result=%0d CF=%0d latency=%0d",
             name, iop, ia, ib, result, CF, edges);
    prev_result = er;
    @(posedge clk);
    @(negedge clk);
    check_val({name, ":valid_pulse"}, 32'(valid), 0);
    check_val({name, ":idle"}, 32'(busy), 0);
    check_val({name, ":stable"}, 32'(result), er);
  endtask

  task automatic check_reset_outputs(input string name);
    check_val({name, ":result"}, 32'(result), 0);
    check_val({name, ":ZF"}, 32'(ZF), 1);
    check_val({name, ":SF"}, 32'(SF), 0);
    check_val({name, ":CF"}, 32'(CF), 0);
    check_val({name, ":GT"}, 32'(gt_zero_flag), 0);
    check_val({name, ":busy"}, 32'(busy), 0);
    check_val({name, ":valid"}, 32'(valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // start low keeps the unit idle
    repeat (3) begin
      @(negedge clk);
      check_val("idle_no_start", 32'(busy), 0);
    end

    run_op(6'b110011, 6'b101010, 0, 1'b0, "xao");
    check_val("xao_const", 32'(result), 32'(6'b100110));
    run_op(6'b110011, 6'b000001, 1, 1'b0, "ror1");
    check_val("ror1_const", 32'(result), 32'(6'b111001));
    run_op(6'b110011, 6'b000111, 1, 1'b0, "ror7");
    run_op(6'b110011, 6'b000110, 1, 1'b0, "ror6");
    run_op(6'b111111, 6'b000001, 2, 1'b0, "add_wrap");
    run_op(6'b000000, 6'b000001, 3, 1'b0, "sub_borrow");
    check_val("sub_const", 32'(result), 32'(6'b111111));
    run_op(6'b110011, 6'b000101, 1, 1'b1, "ror5_repulse");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
    end

    // Reset in the middle of a 5-step rotate, away from any clock edge
    run_op(5, 1, 2, 1'b0, "pre_reset");
    a = 6'b110011;
    b = 6'b000101;
    op = 2'b01;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid_rotate_reset");
    repeat (3) begin
      @(negedge clk);
      check_val("reset_held_valid", 32'(valid), 0);
      check_val("reset_held_busy", 32'(busy), 0);
    end
    reset = 1'b1;
    prev_result = 0;
    run_op(10, 3, 2, 1'b0, "after_reset");
    run_op(6'b110011, 6'b000010, 1, 1'b0, "after_reset_ror");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
